boot_loader: RTL and testbench
==============================

# boot_loader

Serial-stream program loader sitting directly upstream of the instruction RAM's boot port. It consumes a byte stream from the UART receiver, assembles little-endian 32-bit words, and writes them sequentially into instruction RAM through the boot data/control buses. It holds `RstBoot` high for the whole load, which keeps the core in reset and steers the RAM port to the loader, then releases it on success.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000, byte address of the first word written.
- `MAX_WORDS`, 4096, largest accepted word count.
- `TIMEOUT_CYC`, 1_000_000, idle cycles between bytes before a load aborts.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `boot_bypass`  in  1  skip loading; quasi-static.
- `BootDat`  DatBus.Master  —  drives `addr`, `wdata`, `be`.
- `BootCtr`  CtrBus.Master  —  drives `req` and `we`; samples `gnt`; `rvalid`, `rdata` and `err` are ignored.
- `RstBoot`  out  1  high while loading or in error.
- `boot_done`  out  1  load completed.
- `boot_err`  out  1  sticky error flag.

## Operation
- Stream format: 4-byte word count N (LSB first), then N data words (LSB first). With checksum enabled, a 4-byte checksum follows the data words.
- Byte packer:
  - 2-bit byte index plus a 32-bit shift register.
  - Byte k lands in bits [8k+7:8k].
  - `word_valid` pulses on the 4th byte.
- FSM states:
  - LEN: collect the count word.
    - N > MAX_WORDS → ERR.
    - N = 0 → CSUM if enabled, otherwise DONE.
    - Otherwise → DATA, with word index idx = 0.
    - `boot_bypass` = 1 while no byte has arrived → DONE.
  - DATA: wait for `word_valid` → WRITE. Latch wdata; set addr = BASE_ADDR + 4·idx.
  - WRITE:
    - Drive `req` = 1, `we` = 1, `be` = 4'hF; hold addr and wdata stable until `gnt`.
    - On `gnt`: idx++. If idx = N → CSUM if enabled, otherwise DONE. Otherwise → DATA.
  - CSUM: collect 4 bytes. Match → DONE; mismatch → ERR.
  - DONE: `RstBoot` = 0, `boot_done` = 1. Terminal state; further bytes are ignored.
  - ERR: `RstBoot` = 1, `boot_err` = 1. Terminal until `rst_n`.
- The packer keeps accepting bytes during WRITE. If it completes a new word while WRITE is still pending `gnt`, that is an overflow → ERR.
- Timeout:
  - The counter clears on each `rx_valid`.
  - It runs in LEN (only after the first byte), DATA and CSUM.
  - Reaching TIMEOUT_CYC → ERR.
- Arithmetic: idx and N are 32-bit, compared unsigned. The checksum is the mod-2^32 sum of data words. Address computation wraps mod 2^32 (in practice unreachable, given MAX_WORDS).

## Timing
- Reset values:
  - State LEN, `RstBoot` = 1, `boot_done` = 0, `boot_err` = 0.
  - `req` = 0, `we` = 0, `be` = 0, addr = 0, wdata = 0.
  - All counters 0.
- All outputs are registered.
- Latency:
  - `req` rises the cycle after the 4th data byte's `rx_valid`.
  - With a same-cycle `gnt`, `req` is high for exactly 1 cycle.
- `RstBoot` falls and `boot_done` rises in the cycle after the final `gnt`, or after the last checksum byte when enabled.
- Entry into ERR happens the cycle after the detecting event. `req` deasserts in that same cycle.
- `rst_n` asserted mid-load: immediate return to the reset values; RAM contents already written are left as-is.
- `rx_valid` coinciding with `gnt` in WRITE: the byte is accepted and the write completes; both happen in that cycle.

## Configuration
- `BOOT_CHECKSUM_EN` defined: the CSUM state and 32-bit accumulator are present. A trailing checksum word is required, and a mismatch → ERR.
- Not defined: no CSUM state or accumulator. DONE follows the last write directly, and bytes after the data are ignored.

## Structure
- `boot_pkg` holds:
  - the `boot_state_e` enum (LEN, DATA, WRITE, CSUM, DONE, ERR);
  - `BOOT_BE_ALL` = 4'hF;
  - the word-width constants.
- Sub-module `boot_byte_pack`: the byte index, shift register and `word_valid` pulse. It has a synchronous clear input, used by the FSM on state entry.

## Test plan
- Bytes 02 00 00 00, 78 56 34 12, EF BE AD DE (checksum disabled) → write 0x12345678 @0x0, then write 0xDEADBEEF @0x4. `RstBoot` = 0 and `boot_done` = 1 one cycle after the 2nd `gnt`.
- `boot_bypass` = 1 from reset, no bytes → DONE within 2 cycles, no `req`.
- Count bytes 00 00 01 00 (N = 0x10000 > 4096) → `boot_err` = 1, `RstBoot` stays 1, `req` never asserted.
- N = 1, then only 2 data bytes followed by TIMEOUT_CYC idle cycles → ERR; `rst_n` pulse → LEN with all outputs at reset values.
- Bench holds `gnt` = 0 for the first write while 4 more bytes arrive → ERR on the 4th byte; `req` drops the next cycle.
- With `BOOT_CHECKSUM_EN`, N = 2, words 1 and 2:
  - checksum 03 00 00 00 → DONE;
  - checksum 04 00 00 00 → ERR, `RstBoot` stays 1.

Source files
------------

// File: rtl/boot_pkg.sv
// boot_pkg: shared types and constants for the serial boot loader.
//   boot_state_e : loader FSM states
//   BOOT_BE_ALL  : byte-enable for a full 32-bit word write
//   BOOT_WORD_W  : data/address word width
package boot_pkg;

  localparam int unsigned BOOT_WORD_W         = 32;
  localparam int unsigned BOOT_BYTES_PER_WORD = 4;
  localparam logic [3:0]  BOOT_BE_ALL         = 4'hF;

  typedef enum logic [2:0] {
    LEN,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } boot_state_e;

endpackage

// File: rtl/boot_byte_pack.sv
// boot_byte_pack: assembles little-endian 32-bit words from a byte stream.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear of byte index and partial word
//   byte_valid  : byte_data is valid this cycle
//   byte_data   : incoming byte
//   word        : assembled word; valid only while word_valid is high
//   word_valid  : one-cycle pulse in the cycle the 4th byte arrives
module boot_byte_pack
  import boot_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic [BOOT_WORD_W-1:0] word,
  output logic                   word_valid
);

  logic [1:0]             byte_idx;
  logic [BOOT_WORD_W-1:0] shreg;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      shreg    <= '0;
    end else if (clr) begin
      byte_idx <= '0;
      shreg    <= '0;
    end else if (byte_valid) begin
      shreg[8*byte_idx +: 8] <= byte_data;
      byte_idx               <= byte_idx + 2'd1;
    end
  end

  // The 4th byte bypasses the register so the FSM can act in the same cycle;
  // this is what lets req rise the cycle after the last byte's strobe.
  assign word_valid = byte_valid && (byte_idx == 2'd3);

  always_comb begin
    word        = shreg;
    word[31:24] = byte_data;
  end

endmodule

// File: rtl/boot_loader.sv
// boot_loader: loads a program from a UART byte stream into instruction RAM.
// Stream: 4-byte word count N, then N data words, all little-endian.
// Optional feature macro BOOT_CHECKSUM_EN: a trailing 4-byte checksum
// (mod-2^32 sum of the data words) is required; a mismatch is an error.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   rx_data, rx_valid           : received byte and its one-cycle strobe
//   boot_bypass                 : skip loading if set before any byte arrives
//   boot_dat_addr/wdata/be      : boot data bus (byte address, data, enables)
//   boot_ctr_req/we, boot_ctr_gnt : boot control bus handshake
//   RstBoot                     : holds the core in reset while loading/error
//   boot_done, boot_err         : load complete / sticky error
module boot_loader
  import boot_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MAX_WORDS   = 4096,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   boot_bypass,
  output logic [BOOT_WORD_W-1:0] boot_dat_addr,
  output logic [BOOT_WORD_W-1:0] boot_dat_wdata,
  output logic [3:0]             boot_dat_be,
  output logic                   boot_ctr_req,
  output logic                   boot_ctr_we,
  input  logic                   boot_ctr_gnt,
  output logic                   RstBoot,
  output logic                   boot_done,
  output logic                   boot_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

`ifdef BOOT_CHECKSUM_EN
  localparam boot_state_e AFTER_DATA = CSUM;
  logic [BOOT_WORD_W-1:0] acc, acc_next;
`else
  localparam boot_state_e AFTER_DATA = DONE;
`endif

  boot_state_e            state, state_next;
  logic [BOOT_WORD_W-1:0] idx, idx_next;
  logic [BOOT_WORD_W-1:0] n_words, n_next;
  logic [BOOT_WORD_W-1:0] addr_next, wdata_next;
  logic [TO_W-1:0]        to_cnt, to_next, to_inc;
  logic                   got_byte;
  logic                   byte_in, to_run, timeout, load_word, pack_clr;
  logic [BOOT_WORD_W-1:0] word;
  logic                   word_valid;

  // Terminal states ignore the stream entirely.
  assign byte_in = rx_valid && (state != DONE) && (state != ERR);

  boot_byte_pack u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (pack_clr),
    .byte_valid (byte_in),
    .byte_data  (rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // Inter-byte timer: not counted while waiting on gnt, nor before the first byte.
  assign to_run  = ((state == LEN) && got_byte) || (state == DATA) || (state == CSUM);
  assign to_inc  = to_cnt + TO_W'(1);
  assign timeout = to_run && !rx_valid && (to_inc == TO_W'(TIMEOUT_CYC));
  assign to_next = rx_valid ? '0 : (to_run ? to_inc : to_cnt);

  // NOTE: every combinational output gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    n_next     = n_words;
    addr_next  = boot_dat_addr;
    wdata_next = boot_dat_wdata;
    load_word  = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    acc_next   = acc;
`endif

    unique case (state)
      LEN: begin
        if (!got_byte && boot_bypass) begin
          state_next = DONE;
        end else if (word_valid) begin
          n_next   = word;
          idx_next = '0;
          if (word > BOOT_WORD_W'(MAX_WORDS)) state_next = ERR;
          else if (word == '0)                 state_next = AFTER_DATA;
          else                                 state_next = DATA;
        end
      end
      DATA: load_word = word_valid;
      WRITE: begin
        if (boot_ctr_gnt) begin
          idx_next = idx + 32'd1;
          if (idx_next == n_words) begin
            state_next = AFTER_DATA;
`ifdef BOOT_CHECKSUM_EN
            // Checksum word completing on the final grant is checked at once.
            if (word_valid) state_next = (word == acc) ? DONE : ERR;
`endif
          end else if (word_valid) begin
            load_word = 1'b1;  // next word arrived with the grant: chain writes
          end else begin
            state_next = DATA;
          end
        end else if (word_valid) begin
          state_next = ERR;    // a second word while the first is still pending
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CSUM: if (word_valid) state_next = (word == acc) ? DONE : ERR;
`endif
      default: ;
    endcase

    if (load_word) begin
      state_next = WRITE;
      wdata_next = word;
      addr_next  = BASE_ADDR + {idx_next[29:0], 2'b00};
`ifdef BOOT_CHECKSUM_EN
      acc_next   = acc + word;
`endif
    end

    if (timeout) state_next = ERR;
  end

  assign pack_clr = (state_next != state) && ((state_next == DONE) || (state_next == ERR));

  // Outputs are registered from the next state so they change with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= LEN;
      idx            <= '0;
      n_words        <= '0;
      to_cnt         <= '0;
      got_byte       <= 1'b0;
      boot_dat_addr  <= '0;
      boot_dat_wdata <= '0;
      boot_dat_be    <= '0;
      boot_ctr_req   <= 1'b0;
      boot_ctr_we    <= 1'b0;
      RstBoot        <= 1'b1;
      boot_done      <= 1'b0;
      boot_err       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      acc            <= '0;
`endif
    end else begin
      state          <= state_next;
      idx            <= idx_next;
      n_words        <= n_next;
      to_cnt         <= to_next;
      got_byte       <= got_byte | byte_in;
      boot_dat_addr  <= addr_next;
      boot_dat_wdata <= wdata_next;
      boot_dat_be    <= (state_next == WRITE) ? BOOT_BE_ALL : 4'h0;
      boot_ctr_req   <= (state_next == WRITE);
      boot_ctr_we    <= (state_next == WRITE);
      RstBoot        <= (state_next != DONE);
      boot_done      <= (state_next == DONE);
      boot_err       <= (state_next == ERR);
`ifdef BOOT_CHECKSUM_EN
      acc            <= acc_next;
`endif
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed self-checking bench for boot_loader.
// Builds with or without BOOT_CHECKSUM_EN; expectations follow the macro.
module tb_boot_loader;

  localparam int unsigned TO = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        boot_bypass = 1'b0;
  logic        gnt_en = 1'b1;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        req, we, gnt;
  logic        rst_boot, done, err;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr [0:7];
  logic [31:0] wr_data [0:7];
  int          wr_n;
  logic        req_seen;

  always #5 clk = ~clk;

  assign gnt = req & gnt_en;

  boot_loader #(.TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .boot_bypass    (boot_bypass),
    .boot_dat_addr  (addr),
    .boot_dat_wdata (wdata),
    .boot_dat_be    (be),
    .boot_ctr_req   (req),
    .boot_ctr_we    (we),
    .boot_ctr_gnt   (gnt),
    .RstBoot        (rst_boot),
    .boot_done      (done),
    .boot_err       (err)
  );

  // Log of completed writes and any req activity, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_n     <= 0;
      req_seen <= 1'b0;
    end else begin
      if (req) req_seen <= 1'b1;
      if (req && gnt && wr_n < 8) begin
        wr_addr[wr_n] <= addr;
        wr_data[wr_n] <= wdata;
        wr_n          <= wr_n + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Asserts reset mid-cycle, checks reset values asynchronously, releases.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    rx_valid = 1'b0;
    gnt_en   = 1'b1;
    #1;
    check({tag, "_rst_boot"}, 32'(rst_boot), 32'd1);
    check({tag, "_rst_flags"}, {30'd0, done, err}, 32'd0);
    check({tag, "_rst_ctl"}, {26'd0, req, we, be}, 32'd0);
    check({tag, "_rst_addr"}, addr, 32'd0);
    check({tag, "_rst_wdata"}, wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8]);
  endtask

  initial begin
    // ---- two-word load ----
    do_reset("t1");
    send_word(32'h0000_0002);
    check("t1_len_noreq", 32'(req), 32'd0);
    send_word(32'h1234_5678);
    check("t1_w0_req", 32'(req), 32'd1);
    check("t1_w0_ctl", {27'd0, we, be}, 32'h1F);
    check("t1_w0_addr", addr, 32'h0000_0000);
    check("t1_w0_data", wdata, 32'h1234_5678);
    @(negedge clk);
    check("t1_w0_req_1cyc", 32'(req), 32'd0);
    send_word(32'hDEAD_BEEF);
    check("t1_w1_req", 32'(req), 32'd1);
    check("t1_w1_addr", addr, 32'h0000_0004);
    check("t1_w1_data", wdata, 32'hDEAD_BEEF);
    check("t1_busy", {30'd0, rst_boot, done}, 32'h2);
`ifdef BOOT_CHECKSUM_EN
    @(negedge clk);
    check("t1_csum_wait", {30'd0, rst_boot, done}, 32'h2);
    send_word(32'hF0E2_1567);
`else
    @(negedge clk);
`endif
    check("t1_done", {29'd0, rst_boot, done, err}, 32'h2);
    send_word(32'hCAFE_F00D);
    check("t1_ignored_bytes", 32'(wr_n), 32'd2);
    check("t1_log_a0", wr_addr[0], 32'h0000_0000);
    check("t1_log_d1", wr_data[1], 32'hDEAD_BEEF);
    check("t1_still_done", {29'd0, rst_boot, done, err}, 32'h2);

    // ---- bypass ----
    boot_bypass = 1'b1;
    do_reset("byp");
    @(negedge clk);
    check("byp_done", {29'd0, rst_boot, done, err}, 32'h2);
    check("byp_noreq", 32'(req_seen), 32'd0);
    boot_bypass = 1'b0;

    // ---- oversize counts and the MAX_WORDS boundary ----
    do_reset("big");
    send_word(32'h0001_0000);
    check("big_err", {29'd0, rst_boot, done, err}, 32'h5);
    send_word(32'h1111_1111);
    check("big_noreq", 32'(req_seen), 32'd0);
    check("big_sticky", 32'(err), 32'd1);
    do_reset("p4097");
    send_word(32'd4097);
    check("p4097_err", 32'(err), 32'd1);
    do_reset("p4096");
    send_word(32'd4096);
    check("p4096_ok", {29'd0, rst_boot, done, err}, 32'h4);

    // ---- zero-length load ----
    do_reset("n0");
    send_word(32'd0);
`ifdef BOOT_CHECKSUM_EN
    check("n0_csum_wait", {29'd0, rst_boot, done, err}, 32'h4);
    send_word(32'd0);
`endif
    check("n0_done", {29'd0, rst_boot, done, err}, 32'h2);
    check("n0_noreq", 32'(req_seen), 32'd0);

    // ---- timeout ----
    do_reset("to");
    repeat (TO + 5) @(negedge clk);
    check("to_idle_before_first_byte", 32'(err), 32'd0);
    send_word(32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (TO - 1) @(negedge clk);
    check("to_edge_minus1", 32'(err), 32'd0);
    @(negedge clk);
    check("to_err", {29'd0, rst_boot, done, err}, 32'h5);
    check("to_noreq", 32'(req_seen), 32'd0);

    // ---- overflow while a write waits for gnt ----
    do_reset("ov");
    send_word(32'd2);
    gnt_en = 1'b0;
    send_word(32'h4433_2211);
    check("ov_req", 32'(req), 32'd1);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    check("ov_pending", {30'd0, req, err}, 32'h2);
    send_byte(8'h88);
    check("ov_err", {29'd0, rst_boot, req, err}, 32'h5);
    check("ov_nowrite", 32'(wr_n), 32'd0);
    do_reset("ov_after");

`ifdef BOOT_CHECKSUM_EN
    // ---- checksum match / mismatch ----
    do_reset("cs_ok");
    send_word(32'd2);
    send_word(32'd1);
    send_word(32'd2);
    send_word(32'd3);
    check("cs_ok_done", {29'd0, rst_boot, done, err}, 32'h2);
    do_reset("cs_bad");
    send_word(32'd2);
    send_word(32'd1);
    send_word(32'd2);
    send_word(32'd4);
    check("cs_bad_err", {29'd0, rst_boot, done, err}, 32'h5);
    check("cs_bad_writes", 32'(wr_n), 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
